// File: rtl/tow_round_ctrl_pkg.sv
// ============================================================================
// tow_round_ctrl_pkg : shared encodings for the Tug-of-War round sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package tow_round_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_FLASH = 2'd0,
    ST_DARK  = 2'd1,
    ST_PLAY  = 2'd2,
    ST_WIN   = 2'd3
  } state_t;

  localparam logic [1:0] LED_CTRL_DARK  = 2'b00;
  localparam logic [1:0] LED_CTRL_SCORE = 2'b10;
  localparam logic [1:0] LED_CTRL_ALL   = 2'b11;

  localparam logic [2:0] POS_CENTER    = 3'd3;
  localparam logic [2:0] POS_LEFT_END  = 3'd6;
  localparam logic [2:0] POS_RIGHT_END = 3'd0;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b10;
  localparam logic [1:0] WIN_RIGHT = 2'b01;

  function automatic logic [6:0] pos_to_score(input logic [2:0] pos);
    return 7'b0000001 << pos;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pb_edge.sv
// ============================================================================
// pb_edge : single-cycle press pulse from a debounced button level
// Revision: 1.0
// ============================================================================
`default_nettype none

module pb_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic pb,
  output logic press
);

  logic hist_q;
  logic hist_d;

  assign hist_d = pb;
  assign press  = pb & ~hist_q;

  // History resets high so a button held through reset never looks like a press.
  always_ff @(posedge clk) begin
    if (!rst_n) hist_q <= 1'b1;
    else        hist_q <= hist_d;
  end

endmodule

`default_nettype wire

// File: rtl/tow_round_ctrl.sv
// ============================================================================
// tow_round_ctrl : Tug-of-War round sequencer (flash, dark/play, marker, win)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tow_round_ctrl
  import tow_round_ctrl_pkg::*;
#(
  parameter int FLASH_CYCLES = 25,
  parameter int DARK_CYCLES  = 16,
  parameter int CNT_W        = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pb_l,
  input  logic       pb_r,
  output logic [1:0] led_ctrl,
  output logic [6:0] score,
  output logic [1:0] winner,
  output logic       busy_play
);

  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_CYCLES - 1);
  localparam logic [CNT_W-1:0] DARK_LAST  = CNT_W'(DARK_CYCLES - 1);

  logic press_l;
  logic press_r;

  pb_edge u_edge_l (.clk(clk), .rst_n(rst_n), .pb(pb_l), .press(press_l));
  pb_edge u_edge_r (.clk(clk), .rst_n(rst_n), .pb(pb_r), .press(press_r));

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         pos_q, pos_d;
  logic [1:0]         winner_q, winner_d;
  logic [1:0]         led_ctrl_q, led_ctrl_d;
  logic [6:0]         score_q, score_d;
  logic               busy_play_q, busy_play_d;

  logic only_l;
  logic only_r;
  logic any_press;

  assign only_l    = press_l & ~press_r;
  assign only_r    = press_r & ~press_l;
  assign any_press = press_l | press_r;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pos_d    = pos_q;
    winner_d = winner_q;

    case (state_q)
      ST_FLASH: begin
        if (cnt_q == FLASH_LAST) begin
          state_d = ST_DARK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DARK: begin
        // A false start outranks the terminal count and costs the presser a step.
        if (any_press) begin
          cnt_d = '0;
          if (only_l)      pos_d = pos_q - 3'd1;
          else if (only_r) pos_d = pos_q + 3'd1;
        end else if (cnt_q == DARK_LAST) begin
          state_d = ST_PLAY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PLAY: begin
        cnt_d = '0;
        if (any_press) begin
          state_d = ST_DARK;
          if (only_l)      pos_d = pos_q + 3'd1;
          else if (only_r) pos_d = pos_q - 3'd1;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase

    if ((state_q == ST_DARK) || (state_q == ST_PLAY)) begin
      if (pos_d == POS_LEFT_END) begin
        state_d  = ST_WIN;
        winner_d = WIN_LEFT;
      end else if (pos_d == POS_RIGHT_END) begin
        state_d  = ST_WIN;
        winner_d = WIN_RIGHT;
      end
    end

    case (state_d)
      ST_FLASH: led_ctrl_d = LED_CTRL_ALL;
      ST_DARK:  led_ctrl_d = LED_CTRL_DARK;
      default:  led_ctrl_d = LED_CTRL_SCORE;
    endcase
    score_d     = pos_to_score(pos_d);
    busy_play_d = (state_d == ST_PLAY);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_FLASH;
      cnt_q       <= '0;
      pos_q       <= POS_CENTER;
      winner_q    <= WIN_NONE;
      led_ctrl_q  <= LED_CTRL_ALL;
      score_q     <= pos_to_score(POS_CENTER);
      busy_play_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pos_q       <= pos_d;
      winner_q    <= winner_d;
      led_ctrl_q  <= led_ctrl_d;
      score_q     <= score_d;
      busy_play_q <= busy_play_d;
    end
  end

  assign led_ctrl  = led_ctrl_q;
  assign score     = score_q;
  assign winner    = winner_q;
  assign busy_play = busy_play_q;

endmodule

`default_nettype wire

// File: tb/tb_tow_round_ctrl.sv
// ============================================================================
// tb_tow_round_ctrl : directed scoreboard bench for tow_round_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tow_round_ctrl;

  logic       clk;
  logic       rst_n;
  logic       pb_l;
  logic       pb_r;
  logic [1:0] led_ctrl;
  logic [6:0] score;
  logic [1:0] winner;
  logic       busy_play;

  tow_round_ctrl #(
    .FLASH_CYCLES(4),
    .DARK_CYCLES (3),
    .CNT_W       (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pb_l     (pb_l),
    .pb_r     (pb_r),
    .led_ctrl (led_ctrl),
    .score    (score),
    .winner   (winner),
    .busy_play(busy_play)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] led;
    logic [6:0] sc;
    logic [1:0] win;
    logic       busy;
    int         idx;
  } exp_t;

  exp_t exp_q[$];
  int   errors  = 0;
  int   checks  = 0;
  int   step_no = 0;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b0000010;
  localparam logic [6:0] S2 = 7'b0000100;
  localparam logic [6:0] S3 = 7'b0001000;
  localparam logic [6:0] S4 = 7'b0010000;
  localparam logic [6:0] S5 = 7'b0100000;
  localparam logic [6:0] S6 = 7'b1000000;

  // Drive inputs for the next edge and queue the outputs expected after it.
  task automatic step(input logic rn, input logic l, input logic r,
                      input logic [1:0] led, input logic [6:0] sc,
                      input logic [1:0] w, input logic b);
    exp_t e;
    rst_n = rn;
    pb_l  = l;
    pb_r  = r;
    e.led  = led;
    e.sc   = sc;
    e.win  = w;
    e.busy = b;
    e.idx  = step_no;
    step_no++;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n, input logic [1:0] led, input logic [6:0] sc,
                      input logic [1:0] w, input logic b);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, led, sc, w, b);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({led_ctrl, score, winner, busy_play} !== {e.led, e.sc, e.win, e.busy}) begin
          errors++;
          $display("FAIL step%0d outputs: got led=%b score=%b win=%b busy=%b, want led=%b score=%b win=%b busy=%b",
                   e.idx, led_ctrl, score, winner, busy_play, e.led, e.sc, e.win, e.busy);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_n = 1'b0;
    pb_l  = 1'b0;
    pb_r  = 1'b0;
    @(posedge clk);
    #2;

    // Reset state
    step(1'b0, 1'b0, 1'b0, 2'b11, S3, 2'b00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 2'b11, S3, 2'b00, 1'b0);

    // 1: flash, dark, play
    idle(3, 2'b11, S3, 2'b00, 1'b0);
    idle(3, 2'b00, S3, 2'b00, 1'b0);
    idle(3, 2'b10, S3, 2'b00, 1'b1);

    // 2: pb_l held 5 cycles in PLAY counts once
    step(1'b1, 1'b1, 1'b0, 2'b00, S4, 2'b00, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'b00, S4, 2'b00, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'b00, S4, 2'b00, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'b10, S4, 2'b00, 1'b1);
    step(1'b1, 1'b1, 1'b0, 2'b10, S4, 2'b00, 1'b1);
    idle(1, 2'b10, S4, 2'b00, 1'b1);

    // 3: back to centre, then a pb_r false start in DARK cycle 1
    step(1'b1, 1'b0, 1'b1, 2'b00, S3, 2'b00, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'b00, S3, 2'b00, 1'b0);
    step(1'b1, 1'b0, 1'b1, 2'b00, S4, 2'b00, 1'b0);
    idle(2, 2'b00, S4, 2'b00, 1'b0);
    idle(1, 2'b10, S4, 2'b00, 1'b1);

    // 4: simultaneous presses in PLAY then in DARK
    step(1'b1, 1'b1, 1'b1, 2'b00, S4, 2'b00, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'b00, S4, 2'b00, 1'b0);
    step(1'b1, 1'b1, 1'b1, 2'b00, S4, 2'b00, 1'b0);
    idle(2, 2'b00, S4, 2'b00, 1'b0);
    idle(1, 2'b10, S4, 2'b00, 1'b1);

    // False start on the DARK terminal-count cycle beats opening PLAY
    step(1'b1, 1'b1, 1'b0, 2'b00, S5, 2'b00, 1'b0);
    idle(2, 2'b00, S5, 2'b00, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'b00, S4, 2'b00, 1'b0);
    idle(2, 2'b00, S4, 2'b00, 1'b0);
    idle(1, 2'b10, S4, 2'b00, 1'b1);

    // 5: recentre, then three left PLAY wins
    step(1'b1, 1'b0, 1'b1, 2'b00, S3, 2'b00, 1'b0);
    idle(2, 2'b00, S3, 2'b00, 1'b0);
    idle(1, 2'b10, S3, 2'b00, 1'b1);
    step(1'b1, 1'b1, 1'b0, 2'b00, S4, 2'b00, 1'b0);
    idle(2, 2'b00, S4, 2'b00, 1'b0);
    idle(1, 2'b10, S4, 2'b00, 1'b1);
    step(1'b1, 1'b1, 1'b0, 2'b00, S5, 2'b00, 1'b0);
    idle(2, 2'b00, S5, 2'b00, 1'b0);
    idle(1, 2'b10, S5, 2'b00, 1'b1);
    step(1'b1, 1'b1, 1'b0, 2'b10, S6, 2'b10, 1'b0);
    for (int i = 0; i < 20; i++)
      step(1'b1, i[0], i[1], 2'b10, S6, 2'b10, 1'b0);

    // 6a: reset during WIN with pb_l held through it
    step(1'b0, 1'b1, 1'b0, 2'b11, S3, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 2'b11, S3, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 2'b00, S3, 2'b00, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'b10, S3, 2'b00, 1'b1);
    idle(1, 2'b10, S3, 2'b00, 1'b1);

    // 6b: reset during DARK
    step(1'b1, 1'b0, 1'b1, 2'b00, S2, 2'b00, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'b00, S2, 2'b00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 2'b11, S3, 2'b00, 1'b0);
    // Presses during FLASH are ignored
    step(1'b1, 1'b0, 1'b1, 2'b11, S3, 2'b00, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'b11, S3, 2'b00, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'b11, S3, 2'b00, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'b00, S3, 2'b00, 1'b0);

    // Right player wins through repeated left false starts
    step(1'b1, 1'b1, 1'b0, 2'b00, S2, 2'b00, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'b00, S2, 2'b00, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'b00, S1, 2'b00, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'b00, S1, 2'b00, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'b10, S0, 2'b01, 1'b0);
    step(1'b1, 1'b0, 1'b1, 2'b10, S0, 2'b01, 1'b0);
    idle(3, 2'b10, S0, 2'b01, 1'b0);

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tow_round_ctrl.md
Name: tow_round_ctrl

Overview:
Game sequencer for the Tug-of-War board. It drives led_ctrl and score into led_mux.
- Runs the power-on all-LEDs flash.
- Alternates dark (wait) and play (react) phases.
- Detects player button presses, including false starts, and moves the one-hot marker on the 7-LED bar.
- Declares a winner when the marker reaches either end LED.

Parameters:
FLASH_CYCLES, 25, cycles led_ctrl is held at all-on after reset release (board build overrides to about 1 s of clocks)
DARK_CYCLES, 16, cycles of dark phase before play opens (board build overrides)
CNT_W, 32, width of the shared phase counter; must hold max(FLASH_CYCLES, DARK_CYCLES)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
pb_l  in  1  left player button, level, already debounced and synchronised
pb_r  in  1  right player button, level, already debounced and synchronised
led_ctrl  out  2  to led_mux: 2'b11 all on, 2'b10 show score, 2'b00 dark
score  out  7  one-hot marker position to led_mux; bit 6 = left end, bit 0 = right end
winner  out  2  2'b00 none, 2'b10 left won, 2'b01 right won
busy_play  out  1  high while in PLAY (waiting for a reaction)

Behaviour:
- All outputs are registered.
- Reset (rst_n low at a clk edge):
  - state = FLASH, cnt = 0, led_ctrl = 2'b11, score = 7'b0001000 (pos 3), winner = 2'b00, busy_play = 0.
  - Edge-detect history registers load 1, so a button held through reset produces no press.
- Press detection: press_x = pb_x & ~pb_x_q, where pb_x_q is pb_x delayed one cycle.
  - A press takes effect at the clk edge where pb_x is first sampled high.
  - score, state and winner change on that same edge and are visible the following cycle.
  - A held button counts once.
- States and transitions:
  - FLASH:
    - led_ctrl = 11; cnt increments each cycle.
    - When cnt == FLASH_CYCLES-1: go to DARK, cnt = 0.
    - Presses are ignored.
  - DARK:
    - led_ctrl = 00; cnt increments.
    - When cnt == DARK_CYCLES-1 with no press: go to PLAY, cnt = 0.
    - press_l only (false start): marker moves one step right (pos-1). cnt = 0, stay DARK.
    - press_r only (false start): marker moves one step left (pos+1). cnt = 0, stay DARK.
    - Both pressed in the same cycle: no move, cnt = 0, stay DARK.
    - A false-start press on the terminal count cycle wins over the move to PLAY.
  - PLAY:
    - led_ctrl = 10, busy_play = 1. No timeout; cnt is held at 0.
    - press_l only: pos+1. press_r only: pos-1.
    - Both pressed in the same cycle: no move.
    - After any press, go to DARK with cnt = 0.
  - WIN:
    - Entered instead of DARK/PLAY whenever the new pos is 6 (winner = 10) or 0 (winner = 01). This applies to false-start moves too.
    - led_ctrl = 10, score shows the end LED.
    - All presses are ignored; the block holds until reset.
- Position arithmetic:
  - pos is a 3-bit register, range 0..6; score = 1 << pos.
  - pos never leaves 0..6 because WIN is entered at either bound.
- Reset mid-operation: from any state, the next edge with rst_n low restores the reset values above. Nothing else clears WIN.
- Counter: compared against the parameter minus 1. FLASH_CYCLES = 1 and DARK_CYCLES = 1 must work (a one-cycle phase).

Decomposition:
- Shared include tow_defs.vh holds:
  - LED_CTRL_DARK = 2'b00, LED_CTRL_SCORE = 2'b10, LED_CTRL_ALL = 2'b11;
  - state encodings FLASH/DARK/PLAY/WIN;
  - POS_CENTER = 3, POS_LEFT_END = 6, POS_RIGHT_END = 0;
  - WIN_NONE / WIN_LEFT / WIN_RIGHT.
- Sub-module pb_edge: one per button. It holds the history register (reset to 1) and outputs the single-cycle press pulse.
- The FSM, counter and pos register stay in tow_round_ctrl. led_mux is instantiated by the top level, not here.

Test Plan (FLASH_CYCLES = 4, DARK_CYCLES = 3):
1. Reset release, no buttons -> led_ctrl = 11 for 4 cycles, then 00 for 3 cycles, then 10 with score = 0001000 and busy_play = 1.
2. In PLAY, pb_l rises and is held 5 cycles -> one cycle later score = 0010000, led_ctrl = 00. A new DARK runs a full 3 cycles; the hold causes no second move.
3. In DARK cycle 1, pb_r pulses -> score = 0010000 (left gains); the DARK counter restarts, so play opens 3 cycles after the press.
4. pb_l and pb_r rise on the same edge, once in PLAY and once in DARK -> score unchanged. PLAY returns to DARK; DARK restarts its count.
5. Three consecutive PLAY wins by the left player -> score = 1000000, winner = 10, led_ctrl = 10. Further presses are ignored for 20 cycles.
6. rst_n low for 1 cycle during WIN, and separately during DARK -> next cycle led_ctrl = 11, score = 0001000, winner = 00. A pb_l held through reset produces no move.
